fifo_txn_initiator: RTL and testbench



---
 rtl/fifo_txn_initiator_pkg.sv | 20 ++
 rtl/fifo_txn_initiator_occ_counter.sv | 39 +++
 rtl/fifo_txn_initiator.sv | 170 +++++++++++++++++
 tb/tb_fifo_txn_initiator.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_txn_initiator_pkg.sv
// Shared definitions for the FIFO transaction initiator: state encoding,
// opcode values and default geometry.
package fifo_init_pkg;

  localparam int DEPTH_DEF  = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

endpackage

// File: rtl/fifo_txn_initiator_occ_counter.sv
// Occupancy register for the initiator's local view of the FIFO fill level;
// clear has priority, and inc/dec are blocked at the full/empty limits.
module fifo_occ_counter
  import fifo_init_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_full) begin
      r_count <= r_count + CNT_W'(1);
    end else if (i_dec && !o_empty) begin
      r_count <= r_count - CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/fifo_txn_initiator.sv
// Host-side initiator driving the FIFO controller's Start/Write/Done protocol.
// Optional Done timeout with abort is enabled by defining FIFO_INIT_TIMEOUT_EN.
module fifo_txn_initiator
  import fifo_init_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = $clog2(DEPTH) + 1
`ifdef FIFO_INIT_TIMEOUT_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input  logic              clk,
  input  logic              ClearAllReg,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              Start,
  output logic              Write,
  output logic              ClearCtrl_n,
  output logic [DATA_W-1:0] wbuf_data,
  input  logic              Done,
  input  logic [DATA_W-1:0] rbuf_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                w_accept;
  logic                w_reject;
  logic                w_inc;
  logic                w_dec;
  logic                w_clr;

`ifdef FIFO_INIT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] r_tmo;

  always_ff @(posedge clk or posedge ClearAllReg) begin
    if (ClearAllReg) begin
      r_tmo <= '0;
    end else if (r_state == ST_WAIT) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end else begin
      r_tmo <= '0;
    end
  end
`endif

  always_ff @(posedge clk or posedge ClearAllReg) begin
    if (ClearAllReg) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Reject decision uses the pre-transaction occupancy so count can never wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = ((req_write == OP_WRITE) && full) || ((req_write == OP_READ) && empty);
    w_inc       = 1'b0;
    w_dec       = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_reject ? ST_RESP : ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (Done) begin
          w_state_nxt = ST_RESP;
          w_inc       = (r_write == OP_WRITE);
          w_dec       = (r_write == OP_READ);
`ifdef FIFO_INIT_TIMEOUT_EN
        end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
          w_state_nxt = ST_ABORT;
`endif
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_RESP: begin
        w_state_nxt = rsp_ready ? ST_IDLE : ST_RESP;
      end
`ifdef FIFO_INIT_TIMEOUT_EN
      ST_ABORT: begin
        w_clr       = 1'b1;
        w_state_nxt = ST_RESP;
      end
`endif
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge ClearAllReg) begin
    if (ClearAllReg) begin
      r_write <= OP_READ;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_wdata <= req_wdata;
        r_err   <= w_reject;
      end
      if ((r_state == ST_WAIT) && Done) begin
        r_rdata <= (r_write == OP_WRITE) ? '0 : rbuf_data;
      end
`ifdef FIFO_INIT_TIMEOUT_EN
      if (r_state == ST_ABORT) begin
        r_err <= 1'b1;
      end
`endif
      if ((r_state == ST_RESP) && rsp_ready) begin
        r_err   <= 1'b0;
        r_rdata <= '0;
      end
    end
  end

  fifo_occ_counter #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_occ (
    .i_clk   (clk),
    .i_rst   (ClearAllReg),
    .i_inc   (w_inc),
    .i_dec   (w_dec),
    .i_clr   (w_clr),
    .o_count (count),
    .o_full  (full),
    .o_empty (empty)
  );

  assign req_ready   = (r_state == ST_IDLE);
  assign rsp_valid   = (r_state == ST_RESP);
  assign rsp_rdata   = r_rdata;
  assign rsp_err     = r_err;
  assign Start       = (r_state == ST_ISSUE);
  assign Write       = r_write & ((r_state == ST_ISSUE) | (r_state == ST_WAIT));
  assign ClearCtrl_n = !((r_state == ST_INIT) || (r_state == ST_ABORT));
  assign wbuf_data   = r_wdata;

endmodule

// File: tb/tb_fifo_txn_initiator.sv
// Scoreboard bench for fifo_txn_initiator with a behavioural controller that
// returns Done two cycles after Start.
module tb_fifo_txn_initiator;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef struct {
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_write = 1'b0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_ready = 1'b0;
  logic              req_ready, rsp_valid, rsp_err, Start, Write, ClearCtrl_n, full, empty;
  logic [DATA_W-1:0] rsp_rdata, wbuf_data, rbuf_data;
  logic [CNT_W-1:0]  count;
  wire               Done;

  logic              m_done = 1'b0;
  logic              done_force = 1'b0;
  logic              withhold = 1'b0;
  logic [DATA_W-1:0] m_rbuf = '0;
  logic              p1 = 1'b0, p2 = 1'b0, p1_wr = 1'b0, p2_wr = 1'b0;
  logic [DATA_W-1:0] mem_q[$];

  rsp_t              sb_q[$];
  logic [DATA_W-1:0] ref_q[$];
  int                m_count = 0;
  int                n_vec = 0;
  int                n_err = 0;

  assign Done      = m_done | done_force;
  assign rbuf_data = m_rbuf;

  fifo_txn_initiator #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .ClearAllReg(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Start(Start), .Write(Write), .ClearCtrl_n(ClearCtrl_n), .wbuf_data(wbuf_data),
    .Done(Done), .rbuf_data(rbuf_data),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Controller model: Done in the second cycle after Start, read data from its own store.
  always @(negedge clk) begin
    if (rst || !ClearCtrl_n) begin
      m_done <= 1'b0;
      p1     <= 1'b0;
      p2     <= 1'b0;
      mem_q.delete();
    end else begin
      m_done <= p2 & !withhold;
      if (p2 && !withhold && !p2_wr && mem_q.size() > 0) m_rbuf <= mem_q.pop_front();
      p2    <= p1;
      p2_wr <= p1_wr;
      p1    <= Start;
      p1_wr <= Write;
      if (Start && Write) mem_q.push_back(wbuf_data);
    end
  end

  // Response monitor: every handshake must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = sb_q.pop_front();
        check_eq("rsp_err", rsp_err, e.err);
        check_eq("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_req_ready"}, req_ready, 0);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
    check_eq({tag, "_rsp_err"}, rsp_err, 0);
    check_eq({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check_eq({tag, "_start"}, Start, 0);
    check_eq({tag, "_write"}, Write, 0);
    check_eq({tag, "_wbuf"}, wbuf_data, 0);
    check_eq({tag, "_count"}, count, 0);
    check_eq({tag, "_empty"}, empty, 1);
    check_eq({tag, "_full"}, full, 0);
    check_eq({tag, "_clr_n"}, ClearCtrl_n, 0);
  endtask

  // One request/response; called and left at #1 after a rising edge.
  task automatic txn(input logic wr, input logic [DATA_W-1:0] d, input int hold, input bit tmo);
    int   n, lat, starts, clrs;
    bit   rej;
    rsp_t e;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check_eq("req_ready", req_ready, 1);
    rej     = wr ? (m_count == DEPTH) : (m_count == 0);
    e.err   = rej | tmo;
    e.rdata = '0;
    if (tmo) begin
      m_count = 0;
      ref_q.delete();
    end else if (!rej) begin
      if (wr) begin ref_q.push_back(d); m_count++; end
      else begin e.rdata = ref_q.pop_front(); m_count--; end
    end
    sb_q.push_back(e);
    rsp_ready = (hold == 0);
    req_valid = 1'b1; req_write = wr; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; starts = 0; clrs = 0;
    while (!rsp_valid && lat < 40) begin
      starts += int'(Start);
      clrs   += int'(!ClearCtrl_n);
      if (lat == 1) begin
        check_eq("issue_write", Write, wr);
        if (wr) check_eq("issue_wbuf", wbuf_data, d);
      end
      @(posedge clk); #1; lat++;
    end
    check_eq("latency", lat, rej ? 1 : (tmo ? 18 : 4));
    check_eq("start_pulses", starts, rej ? 0 : 1);
    check_eq("clr_pulses", clrs, tmo ? 1 : 0);
    check_eq("start_in_resp", Start, 0);
    for (int i = 0; i < hold; i++) begin
      check_eq("hold_valid", rsp_valid, 1);
      check_eq("hold_rdata", rsp_rdata, e.rdata);
      check_eq("hold_err", rsp_err, e.err);
      check_eq("hold_req_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("rsp_consumed", sb_q.size(), 0);
    check_eq("post_rsp_valid", rsp_valid, 0);
    check_eq("post_rsp_err", rsp_err, 0);
    check_eq("count", count, m_count);
    check_eq("full", full, m_count == DEPTH);
    check_eq("empty", empty, m_count == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("init_clr_n", ClearCtrl_n, 0);
    check_eq("init_req_ready", req_ready, 0);
    @(posedge clk); #1;
    check_eq("idle_clr_n", ClearCtrl_n, 1);
    check_eq("idle_req_ready", req_ready, 1);
    check_eq("idle_count", count, 0);
    check_eq("idle_empty", empty, 1);

    txn(1'b1, 8'hA5, 0, 1'b0);
    txn(1'b0, 8'h00, 0, 1'b0);
    txn(1'b1, 8'h11, 0, 1'b0);
    txn(1'b0, 8'h00, 0, 1'b0);
    txn(1'b0, 8'h00, 0, 1'b0);

    for (int i = 0; i < DEPTH; i++) txn(1'b1, 8'(i * 37 + 3), 0, 1'b0);
    check_eq("full_before_9th", full, 1);
    txn(1'b1, 8'hEE, 0, 1'b0);
    txn(1'b0, 8'h00, 5, 1'b0);
    txn(1'b0, 8'h00, 2, 1'b0);

    done_force = 1'b1;
    @(posedge clk); #1;
    done_force = 1'b0;
    @(posedge clk); #1;
    check_eq("stray_done_count", count, m_count);
    check_eq("stray_done_valid", rsp_valid, 0);
    check_eq("stray_done_ready", req_ready, 1);

`ifdef FIFO_INIT_TIMEOUT_EN
    withhold = 1'b1;
    txn(1'b1, 8'h5A, 0, 1'b1);
    withhold = 1'b0;
    txn(1'b1, 8'h3C, 0, 1'b0);
    txn(1'b0, 8'h00, 0, 1'b0);
`endif

    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_wdata = 8'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("wait_state_write", Write, 1);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    m_count = 0;
    ref_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_eq("midrst_no_rsp", rsp_valid, 0);
    check_eq("midrst_ready", req_ready, 1);
    check_eq("midrst_count", count, 0);
    txn(1'b1, 8'h42, 0, 1'b0);
    txn(1'b0, 8'h00, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
